// File: rtl/rca_lsq_arbiter_pkg.sv
// Shared types and defaults for the RCA load/store-queue arbiter.
package rca_lsq_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int NUM_OU_DEF    = 4;
    localparam int MAX_LOADS_DEF = 4;

    // OU index as stored in the load tag FIFO (default grid size)
    typedef logic [$clog2(NUM_OU_DEF)-1:0] ou_id_t;

    // One OU's memory request as forwarded to the LSQ
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            load;
        logic            store;
    } ou_ls_req_t;

endpackage

// File: rtl/rca_lsq_arbiter_tag_fifo.sv
// Tag FIFO: remembers which OU issued each outstanding load, in issue order.
// Storage is not reset; only pointers and occupancy are.
module rca_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push needs
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage write
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/rca_lsq_arbiter.sv
// Round-robin arbiter sharing one LSQ port among NUM_OU operation units.
// Grants are combinational; load returns are steered back via a tag FIFO.
module rca_lsq_arbiter
    import rca_lsq_arbiter_pkg::*;
#(
    parameter int NUM_OU    = NUM_OU_DEF,
    parameter int MAX_LOADS = MAX_LOADS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_OU*XLEN-1:0]   ou_addr,
    input  logic [NUM_OU*XLEN-1:0]   ou_data,
    input  logic [NUM_OU*3-1:0]      ou_fn3,
    input  logic [NUM_OU-1:0]        ou_load,
    input  logic [NUM_OU-1:0]        ou_store,
    input  logic [NUM_OU-1:0]        ou_new_request,
    output logic [NUM_OU-1:0]        ou_lsq_full,
    output logic [NUM_OU*XLEN-1:0]   ou_load_data,
    output logic [NUM_OU-1:0]        ou_load_complete,
    output logic [XLEN-1:0]          addr,
    output logic [XLEN-1:0]          data,
    output logic [2:0]               fn3,
    output logic                     load,
    output logic                     store,
    output logic                     new_request,
    input  logic                     lsq_full,
    input  logic [XLEN-1:0]          load_data,
    input  logic                     load_complete,
    output logic                     tag_overflow_err
);
    localparam int IDW = $clog2(NUM_OU);

    logic [IDW-1:0]    r_rr_ptr;
    logic              r_err;
    logic [NUM_OU-1:0] w_elig;
    logic              w_grant;
    logic [IDW-1:0]    w_win;
    ou_ls_req_t        w_req;
    logic              w_pop;
    logic              w_push;
    logic              w_space;
    logic              w_empty;
    logic              w_full;
    logic [IDW-1:0]    w_head;

    // A return is only honoured when a tag is waiting; reset suppresses strobes
    assign w_pop   = rst && load_complete && !w_empty;
    // Room for one more load tag, counting the slot freed by this cycle's pop
    assign w_space = !w_full || w_pop;
    // Dual load+store requests are tagged like loads
    assign w_push  = w_grant && w_req.load;

    // Eligibility: request valid, LSQ free, and a tag slot if it is a load
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_OU; i++) begin
            w_elig[i] = rst && !lsq_full && ou_new_request[i] && (!ou_load[i] || w_space);
        end
    end

    // Round-robin pick: first eligible OU at or after r_rr_ptr, wrapping
    always_comb begin
        int             j;
        logic [IDW-1:0] idx;
        w_grant = 1'b0;
        w_win   = '0;
        j       = 0;
        idx     = '0;
        for (int k = 0; k < NUM_OU; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_OU) j = j - NUM_OU;
            idx = IDW'(j);
            if (!w_grant && w_elig[idx]) begin
                w_grant = 1'b1;
                w_win   = idx;
            end
        end
    end

    // Winner field mux; idle bus drives zeros
    always_comb begin
        w_req = '0;
        if (w_grant) begin
            w_req.addr  = ou_addr[int'(w_win)*XLEN +: XLEN];
            w_req.data  = ou_data[int'(w_win)*XLEN +: XLEN];
            w_req.fn3   = ou_fn3[int'(w_win)*3 +: 3];
            w_req.load  = ou_load[w_win];
            w_req.store = ou_store[w_win];
        end
    end

    // Per-OU backpressure and load-return strobes
    always_comb begin
        ou_lsq_full      = '1;
        ou_load_complete = '0;
        if (w_grant) ou_lsq_full[w_win] = 1'b0;
        if (w_pop)   ou_load_complete[w_head] = 1'b1;
    end

    assign addr             = w_req.addr;
    assign data             = w_req.data;
    assign fn3              = w_req.fn3;
    assign load             = w_req.load;
    assign store            = w_req.store;
    assign new_request      = w_grant;
    assign ou_load_data     = {NUM_OU{load_data}};
    assign tag_overflow_err = r_err;

    // Round-robin pointer advances past the winner, holds when idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (w_win == IDW'(NUM_OU - 1)) ? '0 : w_win + 1'b1;
        end
    end

    // Sticky error: a load returned with no tag outstanding
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (load_complete && w_empty) begin
            r_err <= 1'b1;
        end
    end

    rca_tag_fifo #(
        .DEPTH (MAX_LOADS),
        .WIDTH (IDW)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_win),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_rca_lsq_arbiter.sv
// Self-checking bench for rca_lsq_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_rca_lsq_arbiter;
    import rca_lsq_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int ML = 4;
    localparam int XL = XLEN;
    localparam int VW = 6 + 2*XL + 2*N + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*XL-1:0]   ou_addr, ou_data, ou_load_data;
    logic [N*3-1:0]    ou_fn3;
    logic [N-1:0]      ou_load, ou_store, ou_new_request, ou_lsq_full, ou_load_complete;
    logic [XL-1:0]     addr, data, load_data;
    logic [2:0]        fn3;
    logic              load, store, new_request, lsq_full, load_complete, tag_overflow_err;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_ptr = 0;
    int m_q[$];
    bit m_err = 0;
    // per-cycle model expectations
    int            e_win;
    bit            e_pop;
    int            e_strobe;
    bit            e_errset;
    bit            e_isload;
    logic [VW-1:0] e_vec;
    logic [VW-1:0] obs;

    assign obs = {new_request, load, store, fn3, addr, data, ou_lsq_full, ou_load_complete, tag_overflow_err};

    always #5 clk = ~clk;

    rca_lsq_arbiter #(.NUM_OU(N), .MAX_LOADS(ML)) dut (
        .clk              (clk),
        .rst              (rst),
        .ou_addr          (ou_addr),
        .ou_data          (ou_data),
        .ou_fn3           (ou_fn3),
        .ou_load          (ou_load),
        .ou_store         (ou_store),
        .ou_new_request   (ou_new_request),
        .ou_lsq_full      (ou_lsq_full),
        .ou_load_data     (ou_load_data),
        .ou_load_complete (ou_load_complete),
        .addr             (addr),
        .data             (data),
        .fn3              (fn3),
        .load             (load),
        .store            (store),
        .new_request      (new_request),
        .lsq_full         (lsq_full),
        .load_data        (load_data),
        .load_complete    (load_complete),
        .tag_overflow_err (tag_overflow_err)
    );

    // Expected outputs for the current inputs and model state
    task automatic model_eval();
        bit         space;
        logic [N-1:0] one, stb;
        e_pop    = (rst === 1'b1) && load_complete && (m_q.size() > 0);
        e_strobe = e_pop ? m_q[0] : -1;
        e_errset = (rst === 1'b1) && load_complete && (m_q.size() == 0);
        space    = (m_q.size() - int'(e_pop)) < ML;
        e_win    = -1;
        if ((rst === 1'b1) && !lsq_full) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (e_win < 0 && ou_new_request[j] && (!ou_load[j] || space)) e_win = j;
            end
        end
        e_isload = (e_win >= 0) && ou_load[e_win];
        one = '0;
        stb = '0;
        if (e_win >= 0) one[e_win] = 1'b1;
        if (e_pop) stb[e_strobe] = 1'b1;
        if (e_win >= 0)
            e_vec = {1'b1, ou_load[e_win], ou_store[e_win], ou_fn3[e_win*3 +: 3],
                     ou_addr[e_win*XL +: XL], ou_data[e_win*XL +: XL], ~one, stb, m_err};
        else
            e_vec = {6'b0, {2*XL{1'b0}}, {N{1'b1}}, stb, m_err};
    endtask

    // Advance one clock and update the model with what the edge commits
    task automatic tick();
        logic rs;
        model_eval();
        rs = rst;
        @(posedge clk);
        if (rs !== 1'b1) begin
            m_ptr = 0;
            m_q.delete();
            m_err = 0;
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (e_win >= 0) begin
                if (e_isload) m_q.push_back(e_win);
                m_ptr = (e_win + 1) % N;
            end
            if (e_errset) m_err = 1;
        end
        #1;
    endtask

    task automatic clr();
        ou_new_request = '0;
        ou_load        = '0;
        ou_store       = '0;
        ou_addr        = '0;
        ou_data        = '0;
        ou_fn3         = '0;
        lsq_full       = 1'b0;
        load_complete  = 1'b0;
        load_data      = '0;
    endtask

    task automatic req(input int o, input logic [XL-1:0] a, input logic [XL-1:0] d,
                       input logic [2:0] f, input logic ld, input logic st);
        ou_addr[o*XL +: XL] = a;
        ou_data[o*XL +: XL] = d;
        ou_fn3[o*3 +: 3]    = f;
        ou_load[o]          = ld;
        ou_store[o]         = st;
        ou_new_request[o]   = 1'b1;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clr();
        rst = 1'b0;
        for (int i = 0; i < N; i++) req(i, 32'h40 + i, 32'h0, 3'd2, 1'b1, 1'b0);
        load_complete = 1'b1;
        #1;
        total++; if (new_request !== 1'b0) begin bad++; $display("FAIL reset_nreq got=%b want=0", new_request); end
        total++; if (ou_lsq_full !== 4'hF) begin bad++; $display("FAIL reset_full got=%b want=1111", ou_lsq_full); end
        total++; if (ou_load_complete !== 4'h0) begin bad++; $display("FAIL reset_lc got=%b want=0000", ou_load_complete); end
        tick();
        total++; if (tag_overflow_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", tag_overflow_err); end
        clr();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_store_single();
        clr();
        req(2, 32'h100, 32'hDEAD_BEEF, 3'd2, 1'b0, 1'b1);
        #1;
        total++; if (new_request !== 1'b1) begin bad++; $display("FAIL st_nreq got=%b want=1", new_request); end
        total++; if (store !== 1'b1 || load !== 1'b0) begin bad++; $display("FAIL st_flags got=%b%b want=01", load, store); end
        total++; if (addr !== 32'h100) begin bad++; $display("FAIL st_addr got=%h want=00000100", addr); end
        total++; if (data !== 32'hDEAD_BEEF || fn3 !== 3'd2) begin bad++; $display("FAIL st_data got=%h/%0d want=deadbeef/2", data, fn3); end
        total++; if (ou_lsq_full !== 4'b1011) begin bad++; $display("FAIL st_full got=%b want=1011", ou_lsq_full); end
        tick();
        clr();
        #1;
        total++; if (new_request !== 1'b0 || addr !== '0) begin bad++; $display("FAIL st_idle got=%b/%h want=0/0", new_request, addr); end
    endtask

    task automatic test_overflow();
        clr();
        load_complete = 1'b1;
        load_data     = 32'h1234;
        #1;
        total++; if (ou_load_complete !== 4'h0) begin bad++; $display("FAIL ovf_lc got=%b want=0000", ou_load_complete); end
        tick();
        clr();
        #1;
        total++; if (tag_overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", tag_overflow_err); end
        tick();
        tick();
        total++; if (tag_overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", tag_overflow_err); end
    endtask

    task automatic test_reset_mid();
        int src[3] = '{3, 0, 2};
        for (int s = 0; s < 3; s++) begin
            clr();
            req(src[s], 32'h500 + s, 32'h0, 3'd2, 1'b1, 1'b0);
            tick();
        end
        clr();
        rst = 1'b0;
        for (int i = 0; i < N; i++) req(i, 32'h0, 32'h0, 3'd2, 1'b1, 1'b0);
        load_complete = 1'b1;
        #1;
        total++; if (new_request !== 1'b0 || ou_lsq_full !== 4'hF) begin bad++; $display("FAIL rmid_gate got=%b/%b want=0/1111", new_request, ou_lsq_full); end
        total++; if (ou_load_complete !== 4'h0) begin bad++; $display("FAIL rmid_lc got=%b want=0000", ou_load_complete); end
        tick();
        rst = 1'b1;
        clr();
        #1;
        total++; if (tag_overflow_err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b want=0", tag_overflow_err); end
        for (int i = 0; i < N; i++) req(i, 32'h600 + i, 32'h0, 3'd2, 1'b0, 1'b1);
        #1;
        total++; if (ou_lsq_full !== 4'b1110) begin bad++; $display("FAIL rmid_ptr got=%b want=1110", ou_lsq_full); end
        tick();
        clr();
        req(1, 32'h700, 32'h0, 3'd4, 1'b1, 1'b0);
        #1;
        total++; if (ou_lsq_full !== 4'b1101 || load !== 1'b1) begin bad++; $display("FAIL rmid_ld got=%b/%b want=1101/1", ou_lsq_full, load); end
        tick();
        clr();
        load_complete = 1'b1;
        load_data     = 32'h55;
        #1;
        total++; if (ou_load_complete !== 4'b0010) begin bad++; $display("FAIL rmid_ret got=%b want=0010", ou_load_complete); end
        total++; if (ou_load_data[1*XL +: XL] !== 32'h55) begin bad++; $display("FAIL rmid_data got=%h want=00000055", ou_load_data[1*XL +: XL]); end
        tick();
        load_data = 32'h66;
        #1;
        total++; if (ou_load_complete !== 4'h0) begin bad++; $display("FAIL rmid_stale got=%b want=0000", ou_load_complete); end
        tick();
        clr();
    endtask

    task automatic test_rr();
        int seq[6] = '{0, 1, 3, 0, 1, 3};
        logic [N-1:0] want;
        do_reset();
        req(0, 32'h10, 32'hA0, 3'd2, 1'b0, 1'b1);
        req(1, 32'h14, 32'hA1, 3'd2, 1'b0, 1'b1);
        req(3, 32'h1C, 32'hA3, 3'd2, 1'b0, 1'b1);
        for (int s = 0; s < 6; s++) begin
            #1;
            want = ~(4'b0001 << seq[s]);
            total++;
            if (ou_lsq_full !== want || new_request !== 1'b1) begin
                bad++; $display("FAIL rr_step%0d got=%b want=%b", s, ou_lsq_full, want);
            end
            tick();
        end
        clr();
    endtask

    task automatic test_backpressure();
        clr();
        req(1, 32'h80, 32'h81, 3'd1, 1'b0, 1'b1);
        lsq_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (new_request !== 1'b0 || ou_lsq_full[1] !== 1'b1) begin
                bad++; $display("FAIL bp_hold%0d got=%b/%b want=0/1", c, new_request, ou_lsq_full[1]);
            end
            tick();
        end
        lsq_full = 1'b0;
        #1;
        total++; if (ou_lsq_full !== 4'b1101 || new_request !== 1'b1 || addr !== 32'h80) begin bad++; $display("FAIL bp_release got=%b/%b/%h want=1101/1/00000080", ou_lsq_full, new_request, addr); end
        tick();
        clr();
    endtask

    task automatic test_loads();
        int src[4] = '{2, 0, 2, 1};
        int ret[4] = '{0, 2, 1, 3};
        logic [XL-1:0] rdat[4] = '{32'hB, 32'hC, 32'hD, 32'hE};
        logic [N-1:0] want;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            clr();
            req(src[s], 32'h200 + s, 32'h0, 3'd2, 1'b1, 1'b0);
            #1;
            want = ~(4'b0001 << src[s]);
            total++; if (ou_lsq_full !== want || load !== 1'b1) begin bad++; $display("FAIL ld_issue%0d got=%b/%b want=%b/1", s, ou_lsq_full, load, want); end
            tick();
        end
        clr();
        req(3, 32'h300, 32'h0, 3'd2, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (new_request !== 1'b0 || ou_lsq_full !== 4'hF) begin bad++; $display("FAIL ld_block%0d got=%b/%b want=0/1111", c, new_request, ou_lsq_full); end
            tick();
        end
        load_complete = 1'b1;
        load_data     = 32'hA;
        #1;
        total++; if (ou_load_complete !== 4'b0100) begin bad++; $display("FAIL ld_ret0 got=%b want=0100", ou_load_complete); end
        total++; if (ou_load_data !== {N{32'hA}}) begin bad++; $display("FAIL ld_data0 got=%h want=%h", ou_load_data, {N{32'hA}}); end
        total++; if (ou_lsq_full !== 4'b0111 || new_request !== 1'b1 || addr !== 32'h300) begin bad++; $display("FAIL ld_popgrant got=%b/%b/%h want=0111/1/00000300", ou_lsq_full, new_request, addr); end
        tick();
        clr();
        for (int s = 0; s < 4; s++) begin
            load_complete = 1'b1;
            load_data     = rdat[s];
            #1;
            want = 4'b0001 << ret[s];
            total++; if (ou_load_complete !== want) begin bad++; $display("FAIL ld_ret%0d got=%b want=%b", s + 1, ou_load_complete, want); end
            total++; if (ou_load_data[ret[s]*XL +: XL] !== rdat[s]) begin bad++; $display("FAIL ld_rdata%0d got=%h want=%h", s + 1, ou_load_data[ret[s]*XL +: XL], rdat[s]); end
            tick();
        end
        clr();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!ou_new_request[i] && $urandom_range(0, 9) < 4) begin
                    int r;
                    r = $urandom_range(0, 9);
                    req(i, $urandom, $urandom, 3'($urandom_range(0, 7)), r < 5 || r == 9, r >= 5);
                end
            end
            lsq_full = ($urandom_range(0, 4) == 0);
            if (m_q.size() > 0) load_complete = ($urandom_range(0, 2) == 0);
            else                load_complete = ($urandom_range(0, 40) == 0);
            load_data = $urandom;
            #1;
            model_eval();
            total++;
            if (obs !== e_vec) begin bad++; $display("FAIL rnd_out c=%0d got=%h want=%h", c, obs, e_vec); end
            if (e_pop) begin
                total++;
                if (ou_load_data !== {N{load_data}}) begin bad++; $display("FAIL rnd_ldata c=%0d got=%h want=%h", c, ou_load_data, {N{load_data}}); end
            end
            tick();
            if (e_win >= 0) ou_new_request[e_win] = 1'b0;
        end
        clr();
    endtask

    initial begin
        rst = 1'b0;
        clr();
        #1;
        test_reset();
        test_store_single();
        test_overflow();
        test_reset_mid();
        test_rr();
        test_backpressure();
        test_loads();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
